// File: rtl/data_memory_param.sv
// Byte-enabled single-port data memory with a power-up clear sequence and registered reads.
// Optional per-byte even parity storage and checking is enabled by defining DMEM_PARITY_EN.
module data_memory_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    ready,
  output logic                    access_err,
  output logic                    parity_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic                    read_valid_q, read_valid_d;
  logic                    ready_q, ready_d;
  logic                    access_err_q, access_err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NB-1:0]           mem_be;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0]           par_q [DEPTH];
  logic                    parity_err_q, parity_err_d;
  logic                    par_mismatch;

  always_comb begin
    par_mismatch = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (par_q[address][i] != ^mem_q[address][8*i +: 8]) par_mismatch = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    clr_d        = clr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    ready_d      = ready_q;
    access_err_d = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = address;
    mem_wdata    = write_data;
    mem_be       = byte_en;
`ifdef DMEM_PARITY_EN
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_INIT: begin
        // Clear one word per cycle; external requests are rejected meanwhile.
        mem_we       = 1'b1;
        mem_addr     = clr_q;
        mem_wdata    = '0;
        mem_be       = '1;
        access_err_d = mem_read | mem_write;
        clr_d        = clr_q + ADDR_WIDTH'(1);
        ready_d      = 1'b0;
        if (clr_q == '1) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        ready_d = 1'b1;
        mem_we  = mem_write;
        if (mem_read && mem_write) begin
          access_err_d = 1'b1;
        end else if (mem_read) begin
          read_data_d  = mem_q[address];
          read_valid_d = 1'b1;
`ifdef DMEM_PARITY_EN
          parity_err_d = par_mismatch;
`endif
        end
      end
      default: begin
        state_d = S_INIT;
        clr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      clr_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      access_err_q <= 1'b0;
`ifdef DMEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      ready_q      <= ready_d;
      access_err_q <= access_err_d;
`ifdef DMEM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage array has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
          par_q[mem_addr][i] <= ^mem_wdata[8*i +: 8];
`endif
        end
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign ready      = ready_q;
  assign access_err = access_err_q;
`ifdef DMEM_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench for data_memory_param (32-bit words, 256 entries).
module tb_data_memory_param;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          mem_read, mem_write;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [3:0]    byte_en;
  logic [DW-1:0] read_data;
  logic          read_valid, ready, access_err, parity_err;

  data_memory_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .read_data(read_data), .read_valid(read_valid), .ready(ready),
    .access_err(access_err), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [DW-1:0] data; logic perr; } exp_t;
  exp_t rd_q[$];
  int   acc_exp = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clock) begin
    if (!reset) begin
      if (read_valid) begin
        if (rd_q.size() == 0) check("spurious_read_valid", {31'd0, read_valid}, 0);
        else begin
          exp_t e;
          e = rd_q.pop_front();
          check("read_data", read_data, e.data);
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        end
      end else if (parity_err) begin
        check("parity_err_without_valid", {31'd0, parity_err}, 0);
      end
      if (access_err) begin
        if (acc_exp == 0) check("spurious_access_err", {31'd0, access_err}, 0);
        else begin
          acc_exp--;
          check("access_err", {31'd0, access_err}, 1);
        end
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clock);
    mem_read = rd; mem_write = wr; address = a; write_data = d; byte_en = be;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd_exp(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic perr);
    exp_t e;
    req(1'b1, 1'b0, a, '0, '0);
    e.data = d; e.perr = perr;
    rd_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(name, n, 256);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_read_data"}, read_data, 0);
    check({name, "_flags"}, {27'd0, read_valid, ready, access_err, parity_err, 1'b0}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_read = 0; mem_write = 0; address = '0; write_data = '0; byte_en = '0;
    #7;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    wait_ready("ready_latency_first");

    // Freshly cleared memory reads zero everywhere.
    rd_exp(8'h00, 32'h0, 1'b0);
    rd_exp(8'h7F, 32'h0, 1'b0);
    rd_exp(8'hFF, 32'h0, 1'b0);

    req(1'b0, 1'b1, 8'h00, 32'h0000_0008, 4'b0001);
    rd_exp(8'h00, 32'h0000_0008, 1'b0);

    req(1'b0, 1'b1, 8'h10, 32'hAABB_CCDD, 4'b1111);
    req(1'b0, 1'b1, 8'h10, 32'h1122_3344, 4'b0101);
    rd_exp(8'h10, 32'hAA22_CC44, 1'b0);
    req(1'b0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0000);
    rd_exp(8'h10, 32'hAA22_CC44, 1'b0);

    // Simultaneous read+write: write lands, read dropped.
    req(1'b1, 1'b1, 8'hFF, 32'h0000_005A, 4'b1111);
    acc_exp++;
    idle(1);
    rd_exp(8'hFF, 32'h0000_005A, 1'b0);

    rd_exp(8'h00, 32'h0000_0008, 1'b0);
    rd_exp(8'h10, 32'hAA22_CC44, 1'b0);
    rd_exp(8'hFF, 32'h0000_005A, 1'b0);
    idle(3);
    check("read_data_hold", read_data, 32'h0000_005A);

    req(1'b0, 1'b1, 8'h20, 32'hDEAD_BEEF, 4'b1111);
    rd_exp(8'h20, 32'hDEAD_BEEF, 1'b0);
    idle(2);

    // Reset with a read pending: no read_valid may appear.
    req(1'b1, 1'b0, 8'h10, '0, '0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_idle");
    @(negedge clock);
    mem_read = 1'b0; reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      mem_read  = (i == 5);
      mem_write = (i == 10);
      if (i == 5 || i == 10) acc_exp++;
    end
    check("ready_low_in_init", {31'd0, ready}, 0);
    @(negedge clock);
    mem_write = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_init");
    @(negedge clock);
    reset = 1'b0;
    wait_ready("ready_latency_restart");

    rd_exp(8'h10, 32'h0, 1'b0);
    rd_exp(8'h20, 32'h0, 1'b0);

`ifdef DMEM_PARITY_EN
    idle(1);
    dut.par_q[3][0] = ~dut.par_q[3][0];
    rd_exp(8'h03, 32'h0, 1'b1);
`else
    rd_exp(8'h03, 32'h0, 1'b0);
`endif
    idle(4);

    check("pending_reads", rd_q.size(), 0);
    check("pending_access_err", acc_exp, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
